// File: rtl/axis_meter_pkg.sv
// Shared types and helpers for the AXI-Stream keep/byte meter.
// Contents:
//   KEEP_MAX_W / BYTES_MAX_W : widest supported keep (1024-bit data) and its count width
//   keep_bw()                : width of a byte count for a given keep width
//   keep_popcount()          : number of set keep bits
//   keep_is_sparse()         : keep nonzero with more than one run of ones
//   stage1_t                 : registered per-beat result
//   meter_state_e            : packet tracking state
package axis_meter_pkg;

    localparam int unsigned KEEP_MAX_W  = 128;
    localparam int unsigned BYTES_MAX_W = 8;

    function automatic int unsigned keep_bw(input int unsigned keep_w);
        return $clog2(keep_w + 1);
    endfunction

    function automatic logic [BYTES_MAX_W-1:0] keep_popcount(input logic [KEEP_MAX_W-1:0] keep);
        logic [BYTES_MAX_W-1:0] n;
        n = '0;
        for (int unsigned i = 0; i < KEEP_MAX_W; i++) begin
            n = n + BYTES_MAX_W'(keep[i]);
        end
        return n;
    endfunction

    // Counts rising edges of the keep vector (with an implicit 0 below bit 0);
    // more than one rising edge means the ones are not a single run.
    function automatic logic keep_is_sparse(input logic [KEEP_MAX_W-1:0] keep);
        int unsigned runs;
        logic        prev;
        runs = 0;
        prev = 1'b0;
        for (int unsigned i = 0; i < KEEP_MAX_W; i++) begin
            if (keep[i] && !prev) begin
                runs = runs + 1;
            end
            prev = keep[i];
        end
        return (runs > 1);
    endfunction

    typedef struct packed {
        logic [BYTES_MAX_W-1:0] bytes;
        logic                   sparse;
        logic                   last;
        logic                   valid;
    } stage1_t;

    typedef enum logic {
        ST_IDLE   = 1'b0,
        ST_IN_PKT = 1'b1
    } meter_state_e;

endpackage

// File: rtl/axis_keep_byte_meter_keep_stats.sv
// keep_stats: combinational byte count and sparse flag for one keep vector.
// Ports:
//   i_keep   in  KEEP_W  keep vector
//   o_bytes  out BW      number of set keep bits
//   o_sparse out 1       keep nonzero and not one contiguous run
module keep_stats
    import axis_meter_pkg::*;
#(
    parameter  int unsigned KEEP_W = 4,
    localparam int unsigned BW     = keep_bw(KEEP_W)
) (
    input  logic [KEEP_W-1:0] i_keep,
    output logic [BW-1:0]     o_bytes,
    output logic              o_sparse
);

    logic [KEEP_MAX_W-1:0] w_keep_ext;

    assign w_keep_ext = KEEP_MAX_W'(i_keep);
    assign o_bytes    = BW'(keep_popcount(w_keep_ext));
    assign o_sparse   = keep_is_sparse(w_keep_ext);

endmodule

// File: rtl/axis_keep_byte_meter.sv
// axis_keep_byte_meter: passive AXI-Stream snooper reporting per-beat byte
// counts, per-packet byte/flit totals with sparse/overflow flags, and running
// byte/packet totals.
// Ports:
//   clk, aresetn                         clock, async active-low reset
//   snoop_tvalid/tready/tkeep/tlast      observed bus (never driven)
//   clear                                sync clear of totals and packet in progress
//   beat_bytes, beat_valid               per-beat count, one cycle after acceptance
//   pkt_bytes, pkt_flits, pkt_valid,
//   pkt_sparse, pkt_overflow             completed packet, two cycles after tlast
//   total_bytes, total_pkts              wrapping running totals
module axis_keep_byte_meter
    import axis_meter_pkg::*;
#(
    parameter  int unsigned TDATA_WIDTH = 32,
    parameter  int unsigned TKEEP_WIDTH = TDATA_WIDTH / 8,
    parameter  int unsigned LEN_WIDTH   = 16,
    parameter  int unsigned CNT_WIDTH   = 32,
    localparam int unsigned BW          = keep_bw(TKEEP_WIDTH)
) (
    input  logic                   clk,
    input  logic                   aresetn,
    input  logic                   snoop_tvalid,
    input  logic                   snoop_tready,
    input  logic [TKEEP_WIDTH-1:0] snoop_tkeep,
    input  logic                   snoop_tlast,
    input  logic                   clear,
    output logic [BW-1:0]          beat_bytes,
    output logic                   beat_valid,
    output logic [LEN_WIDTH-1:0]   pkt_bytes,
    output logic [LEN_WIDTH-1:0]   pkt_flits,
    output logic                   pkt_valid,
    output logic                   pkt_sparse,
    output logic                   pkt_overflow,
    output logic [CNT_WIDTH-1:0]   total_bytes,
    output logic [CNT_WIDTH-1:0]   total_pkts
);

    if (TDATA_WIDTH < 8 || TDATA_WIDTH > 1024 || (TDATA_WIDTH % 8) != 0 ||
        TKEEP_WIDTH != TDATA_WIDTH / 8) begin : g_bad_width
        $error("axis_keep_byte_meter: unsupported TDATA_WIDTH/TKEEP_WIDTH");
    end

    // Byte sum is wide enough for a saturated accumulator plus a full beat.
    localparam int unsigned SW = ((LEN_WIDTH > BYTES_MAX_W) ? LEN_WIDTH : BYTES_MAX_W) + 1;

    logic [BW-1:0]        w_bytes;
    logic                 w_sparse;
    logic                 w_capture;
    stage1_t              r_s1;

    meter_state_e         r_state;
    meter_state_e         w_state_nxt;

    logic [LEN_WIDTH-1:0] r_acc_bytes;
    logic [LEN_WIDTH-1:0] r_acc_flits;
    logic                 r_acc_sparse;
    logic                 r_acc_ovf;

    logic [LEN_WIDTH-1:0] w_base_bytes;
    logic [LEN_WIDTH-1:0] w_base_flits;
    logic                 w_base_sparse;
    logic                 w_base_ovf;
    logic [SW-1:0]        w_sum_bytes;
    logic [LEN_WIDTH:0]   w_sum_flits;
    logic                 w_sat_bytes;
    logic                 w_sat_flits;
    logic [LEN_WIDTH-1:0] w_nxt_bytes;
    logic [LEN_WIDTH-1:0] w_nxt_flits;
    logic                 w_nxt_sparse;
    logic                 w_nxt_ovf;

    logic [LEN_WIDTH-1:0] r_pkt_bytes;
    logic [LEN_WIDTH-1:0] r_pkt_flits;
    logic                 r_pkt_valid;
    logic                 r_pkt_sparse;
    logic                 r_pkt_ovf;
    logic [CNT_WIDTH-1:0] r_total_bytes;
    logic [CNT_WIDTH-1:0] r_total_pkts;

    keep_stats #(
        .KEEP_W (TKEEP_WIDTH)
    ) u_keep_stats (
        .i_keep   (snoop_tkeep),
        .o_bytes  (w_bytes),
        .o_sparse (w_sparse)
    );

    // A beat accepted while clear is high is dropped.
    assign w_capture = snoop_tvalid && snoop_tready && !clear;

    // Stage 1: payload only loads on a captured beat so beat_bytes holds.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_s1 <= '0;
        end else begin
            r_s1.valid <= w_capture;
            if (w_capture) begin
                r_s1.bytes  <= BYTES_MAX_W'(w_bytes);
                r_s1.sparse <= w_sparse;
                r_s1.last   <= snoop_tlast;
            end
        end
    end

    // In IDLE the accumulator base is zero, so a beat directly following a
    // completion starts the new packet from its own values with no bubble.
    always_comb begin
        w_state_nxt   = r_state;
        w_base_bytes  = '0;
        w_base_flits  = '0;
        w_base_sparse = 1'b0;
        w_base_ovf    = 1'b0;
        if (r_state == ST_IN_PKT) begin
            w_base_bytes  = r_acc_bytes;
            w_base_flits  = r_acc_flits;
            w_base_sparse = r_acc_sparse;
            w_base_ovf    = r_acc_ovf;
        end
        w_sum_bytes  = SW'(w_base_bytes) + SW'(r_s1.bytes);
        w_sum_flits  = {1'b0, w_base_flits} + {{LEN_WIDTH{1'b0}}, 1'b1};
        w_sat_bytes  = |(w_sum_bytes >> LEN_WIDTH);
        w_sat_flits  = w_sum_flits[LEN_WIDTH];
        w_nxt_bytes  = w_sat_bytes ? '1 : w_sum_bytes[LEN_WIDTH-1:0];
        w_nxt_flits  = w_sat_flits ? '1 : w_sum_flits[LEN_WIDTH-1:0];
        w_nxt_sparse = w_base_sparse | r_s1.sparse;
        w_nxt_ovf    = w_base_ovf | w_sat_bytes | w_sat_flits;

        if (clear) begin
            w_state_nxt = ST_IDLE;
        end else if (r_s1.valid) begin
            w_state_nxt = r_s1.last ? ST_IDLE : ST_IN_PKT;
        end
    end

    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Stage 2: accumulate, complete, and update totals. clear beats completion.
    always_ff @(posedge clk or negedge aresetn) begin
        if (!aresetn) begin
            r_acc_bytes   <= '0;
            r_acc_flits   <= '0;
            r_acc_sparse  <= 1'b0;
            r_acc_ovf     <= 1'b0;
            r_pkt_bytes   <= '0;
            r_pkt_flits   <= '0;
            r_pkt_valid   <= 1'b0;
            r_pkt_sparse  <= 1'b0;
            r_pkt_ovf     <= 1'b0;
            r_total_bytes <= '0;
            r_total_pkts  <= '0;
        end else begin
            r_pkt_valid <= 1'b0;
            if (clear) begin
                r_acc_bytes   <= '0;
                r_acc_flits   <= '0;
                r_acc_sparse  <= 1'b0;
                r_acc_ovf     <= 1'b0;
                r_total_bytes <= '0;
                r_total_pkts  <= '0;
            end else if (r_s1.valid) begin
                if (r_s1.last) begin
                    r_pkt_bytes   <= w_nxt_bytes;
                    r_pkt_flits   <= w_nxt_flits;
                    r_pkt_sparse  <= w_nxt_sparse;
                    r_pkt_ovf     <= w_nxt_ovf;
                    r_pkt_valid   <= 1'b1;
                    r_total_bytes <= r_total_bytes + CNT_WIDTH'(w_nxt_bytes);
                    r_total_pkts  <= r_total_pkts + 1'b1;
                    r_acc_bytes   <= '0;
                    r_acc_flits   <= '0;
                    r_acc_sparse  <= 1'b0;
                    r_acc_ovf     <= 1'b0;
                end else begin
                    r_acc_bytes   <= w_nxt_bytes;
                    r_acc_flits   <= w_nxt_flits;
                    r_acc_sparse  <= w_nxt_sparse;
                    r_acc_ovf     <= w_nxt_ovf;
                end
            end
        end
    end

    assign beat_bytes   = BW'(r_s1.bytes);
    assign beat_valid   = r_s1.valid;
    assign pkt_bytes    = r_pkt_bytes;
    assign pkt_flits    = r_pkt_flits;
    assign pkt_valid    = r_pkt_valid;
    assign pkt_sparse   = r_pkt_sparse;
    assign pkt_overflow = r_pkt_ovf;
    assign total_bytes  = r_total_bytes;
    assign total_pkts   = r_total_pkts;

endmodule

// File: doc/axis_keep_byte_meter.md
Name: axis_keep_byte_meter

Overview:
- Parametrised successor to the fixed 4-bit keep-to-byte-count converter in the traffic monitor packet snooper.
- Passively snoops one AXI-Stream interface. Per accepted beat it reports the byte count for any TKEEP_WIDTH.
- Per packet it accumulates byte and flit counts, and flags sparse keep patterns and length overflow.
- Maintains running totals of bytes and packets for the monitor register block.

Parameters:
- TDATA_WIDTH, 32: snooped data width in bits; must be a multiple of 8, range 8..1024.
- TKEEP_WIDTH, TDATA_WIDTH/8: keep width.
- LEN_WIDTH, 16: width of the per-packet byte and flit counters.
- CNT_WIDTH, 32: width of the running total counters.

Ports:
- clk  in  1  clock.
- aresetn  in  1  asynchronous active-low reset.
- snoop_tvalid  in  1  observed tvalid.
- snoop_tready  in  1  observed tready.
- snoop_tkeep  in  TKEEP_WIDTH  observed tkeep.
- snoop_tlast  in  1  observed tlast.
- clear  in  1  synchronous clear of totals and the in-progress packet.
- beat_bytes  out  BW=$clog2(TKEEP_WIDTH+1)  byte count of the last accepted beat.
- beat_valid  out  1  one-cycle pulse qualifying beat_bytes.
- pkt_bytes  out  LEN_WIDTH  total bytes of the completed packet.
- pkt_flits  out  LEN_WIDTH  total beats of the completed packet, including zero-keep beats.
- pkt_valid  out  1  one-cycle pulse qualifying the pkt_* outputs.
- pkt_sparse  out  1  completed packet contained at least one non-contiguous keep.
- pkt_overflow  out  1  pkt_bytes or pkt_flits saturated.
- total_bytes  out  CNT_WIDTH  running byte total, wraps modulo 2^CNT_WIDTH.
- total_pkts  out  CNT_WIDTH  running packet total, wraps.

Behaviour:
- Beat acceptance: a beat is accepted when snoop_tvalid && snoop_tready. The block never drives the bus.
- Reset: on aresetn low, every output and all internal state go to 0 immediately. The FSM enters IDLE.
- Stage 1 (registered):
  - Computes popcount(tkeep), which counts every set bit, not just contiguous ones.
  - Computes sparse = keep nonzero and its ones do not form a single contiguous run.
  - Captures last = tlast.
  - beat_bytes and beat_valid are driven from this stage, one cycle after acceptance.
  - beat_bytes holds its value when beat_valid is 0.
- Stage 2 (accumulate):
  - Adds the stage-1 result to the byte accumulator and increments the flit accumulator.
  - Both accumulators saturate at 2^LEN_WIDTH-1. On saturation a sticky ovf bit is set.
  - OR-accumulates the sparse bit.
- Packet completion:
  - When the stage-1 entry has last=1, stage 2 loads pkt_bytes and pkt_flits with the final sums, including this beat.
  - It also loads pkt_sparse and pkt_overflow.
  - pkt_valid pulses 2 cycles after the tlast beat is accepted.
  - In the same cycle, total_bytes += the final sum and total_pkts += 1.
  - The accumulators reset to 0, ready for the next packet.
  - pkt_* outputs hold until the next completion.
- FSM (2 states):
  - IDLE to IN_PKT on a stage-1 entry with last=0.
  - IN_PKT stays on last=0 and returns to IDLE on last=1.
  - A single-beat packet (last=1 from IDLE) completes without entering IN_PKT.
- Back-to-back operation: full throughput, one beat per cycle. A tlast beat followed immediately by a new beat is handled as:
  - the accumulators are restarted with the new beat's values, not zero-then-add;
  - no bubble is inserted.
- Zero-keep beat: counts as a flit with 0 bytes. It is not sparse.
- clear:
  - Zeroes total_*, the accumulators, the FSM and stage-1 valid on the next edge.
  - Beats in stage 1 are discarded.
  - If clear coincides with a completion, clear wins: no pkt_valid and no total update.
  - pkt_* registers are not cleared.
  - A beat accepted in the clear cycle is dropped.
- Reset mid-packet: the partial packet is discarded silently. There is no pkt_valid on exit from reset.

Decomposition:
- Package axis_meter_pkg contains:
  - function keep_popcount(keep);
  - function keep_is_sparse(keep);
  - localparam helper for BW;
  - typedef struct stage1_t {bytes, sparse, last, valid}.
- Sub-module keep_stats (combinational): keep in, bytes and sparse out. Reused by future multi-channel snoopers.

Test Plan:
- TDATA_WIDTH=32, single beat, keep=4'hF, tlast=1: beat_bytes=4 at +1 cycle; pkt_valid at +2 with pkt_bytes=4, pkt_flits=1; total_pkts=1.
- Packet of keeps F,F,F,7 (last): pkt_bytes=15, pkt_flits=4, pkt_sparse=0. Back-to-back next packet keep=1 (last): pkt_bytes=1, total_bytes=16, total_pkts=2.
- TDATA_WIDTH=64, keep=8'hA5, tlast=1: beat_bytes=4, pkt_sparse=1. Keep=8'h00 mid-packet: flit counted, 0 bytes.
- LEN_WIDTH=4, 5 beats of keep F: pkt_bytes=15 (saturated), pkt_overflow=1, pkt_flits=5.
- Assert clear in the cycle the tlast-beat result is in stage 1: no pkt_valid, total_bytes=0, total_pkts=0.
- Drop aresetn asynchronously between clock edges mid-packet: all outputs read 0 before the next edge; the first packet after release reports only its own bytes.
